pwm_ramp_ctrl: RTL and testbench
================================

# pwm_ramp_ctrl

Upstream control stage for the PWM generator. Accepts a new period/duty target over a valid/ready handshake. Drives the generator's `total_dur`/`high_dur` inputs, changing them only at PWM period boundaries. Ramps `high_dur` toward the target in bounded steps, one step per period, for soft-start and soft-stop of the driven load.

## Interface
- `WIDTH`, 32: width of `total_dur`/`high_dur` and the internal tick.
- `STEP_W`, 16: width of the ramp step.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low. The clock is `clk`; reset is synchronous and active-low.
- `cfg_valid`  in  1: new target offered.
- `cfg_ready`  out  1: block can accept a target.
- `cfg_total`  in  WIDTH: target period value; period length is `cfg_total`+1 cycles.
- `cfg_high`  in  WIDTH: target high duration.
- `cfg_step`  in  STEP_W: high-duration change per period; 0 means jump.
- `total_dur`  out  WIDTH: to generator; registered.
- `high_dur`  out  WIDTH: to generator; registered.
- `busy`  out  1: request in progress (state ≠ IDLE).
- `period_end`  out  1: one-cycle pulse in the first cycle of each new period (tick==0).

## Operation
- Internal tick mirrors the generator: if tick ≥ `total_dur` then tick←0, else tick+1. A "boundary edge" is any edge where tick wraps to 0.
- States:
  - IDLE: `cfg_ready`=1. When `cfg_valid`&&`cfg_ready` (acceptance edge), latch `tgt_total`=`cfg_total`, `tgt_high`=min(`cfg_high`,`cfg_total`), and `step`; go to WAIT_BOUND.
  - WAIT_BOUND: at the first boundary edge strictly after acceptance:
    - `total_dur`←`tgt_total`.
    - `high_dur`←first step from base=min(`high_dur`,`tgt_total`).
    - Go to RAMP, or to IDLE if `high_dur` reaches `tgt_high`.
  - RAMP: at each boundary edge, step `high_dur` toward `tgt_high`; go to IDLE on the edge where it reaches `tgt_high`.
- Step arithmetic:
  - Computed in WIDTH+1 bits and saturating at `tgt_high`; never overshoots, never underflows.
  - Up: if `tgt_high`−h ≤ step, then h←`tgt_high`, else h+step.
  - Down: if h−`tgt_high` ≤ step, then h←`tgt_high`, else h−step.
  - `step`=0 means h←`tgt_high` directly.
- `cfg_valid` outside IDLE is ignored (`cfg_ready`=0); the requester holds it.
- Target equal to current outputs: still takes one boundary, then returns to IDLE.
- `cfg_total`=0: boundary on every edge; ramp advances every cycle.

## Timing
- Reset values (edge with `rst_n`=0): `total_dur`=0, `high_dur`=0, tick=0, `period_end`=0, `busy`=0, `cfg_ready`=0, state IDLE. `cfg_ready` is 1 from the first cycle after reset release.
- `rst_n` low mid-ramp: the next edge restores reset values; the pending target is discarded.
- `cfg_ready` and `busy` are registered decodes of state.
  - Acceptance edge E: `busy`=1 and `cfg_ready`=0 from E+1.
  - The edge that returns to IDLE makes `cfg_ready`=1 in the next cycle; back-to-back acceptance is possible one cycle later.
- `total_dur`/`high_dur` change only on boundary edges. New values are visible in the same cycle that `period_end`=1.
- Latency from acceptance to first output change is 1 to `total_dur`+1 cycles (old period).
- Ramp duration in periods is ceil(|Δhigh|/step), with a minimum of 1.

## Configuration
- `PWM_RAMP_EN` defined: ramp behaviour as above.
- `PWM_RAMP_EN` undefined:
  - RAMP state and step arithmetic are not built; `cfg_step` is present but ignored.
  - WAIT_BOUND loads `total_dur`=`tgt_total` and `high_dur`=`tgt_high` at the first boundary edge, then returns to IDLE.

## Structure
- Shared package `pwm_pkg`: state enum (IDLE, WAIT_BOUND, RAMP), default WIDTH/STEP_W constants.
- Sub-module `pwm_period_counter`: tick register, boundary detect, `period_end` register.
  - Inputs: `clk`, `rst_n`, `total_dur`.
  - Outputs: `boundary`, `period_end`.
- Top level holds the FSM, target registers and saturating step logic.

## Test plan
- Reset then idle: `rst_n` low for 3 cycles → all outputs 0, `cfg_ready`=0. After release, `period_end` pulses every cycle and `cfg_ready`=1.
- Ramp up (`PWM_RAMP_EN`): from total=99/high=0, send total=99, high=50, step=20 → `high_dur` goes 20, 40, 50 on three consecutive boundaries (100-cycle spacing), then `busy`=0.
- Ramp down with clamp: from total=99/high=50, send total=29, high=40, step=8.
  - `tgt_high` stays 29 (40 clamped to 29, not >29); first boundary gives `total_dur`=29 and `high_dur`=min(50,29)→ at target 29 immediately → IDLE.
  - Second run, send high=5 → 21, 13, 5.
- Step=0 and macro-off build: total=9, high=7 → both load on the first boundary after acceptance; `busy` lasts 1 to 10 cycles plus 1.
- Handshake: hold `cfg_valid` with alternating data during RAMP → no acceptance until `cfg_ready`=1; data latched only on the accepting edge.
- Reset mid-ramp: assert `rst_n`=0 between steps → next edge gives `total_dur`=`high_dur`=0, state IDLE; no further steps.

Source files
------------

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared state encoding and default widths for the PWM ramp control.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  localparam int c_default_width  = 32;
  localparam int c_default_step_w = 16;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_BOUND = 2'd1,
    ST_RAMP       = 2'd2
  } pwm_state_e;

endpackage
`default_nettype wire

// File: rtl/pwm_period_counter.sv
`default_nettype none
// ============================================================================
// Module   : pwm_period_counter
// Purpose  : Mirrors the generator's tick; flags boundary edges, pulses
//            period_end in the first cycle of every period.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] total_dur,
  output logic             boundary,
  output logic             period_end
);

  logic [WIDTH-1:0] r_tick;
  logic             r_period_end;

  // >= rather than == so a shrinking total_dur can never strand the tick
  assign boundary = (r_tick >= total_dur);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick       <= '0;
      r_period_end <= 1'b0;
    end else begin
      r_tick       <= boundary ? '0 : r_tick + WIDTH'(1);
      r_period_end <= boundary;
    end
  end

  assign period_end = r_period_end;

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_ctrl
// Purpose  : Accepts period/duty targets and applies them to the generator
//            at period boundaries, ramping high_dur when PWM_RAMP_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int WIDTH  = c_default_width,
  parameter int STEP_W = c_default_step_w
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_total,
  input  logic [WIDTH-1:0]  cfg_high,
  input  logic [STEP_W-1:0] cfg_step,
  output logic [WIDTH-1:0]  total_dur,
  output logic [WIDTH-1:0]  high_dur,
  output logic              busy,
  output logic              period_end
);

  pwm_state_e       r_state;
  pwm_state_e       w_state_nxt;
  logic             r_cfg_ready;
  logic             r_busy;
  logic [WIDTH-1:0] r_total;
  logic [WIDTH-1:0] r_high;
  logic [WIDTH-1:0] r_tgt_total;
  logic [WIDTH-1:0] r_tgt_high;
  logic [WIDTH-1:0] w_cfg_high_clamped;
  logic [WIDTH-1:0] w_high_nxt;
  logic             w_boundary;
  logic             w_accept;
  logic             w_load;

  pwm_period_counter #(
    .WIDTH (WIDTH)
  ) u_period_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .total_dur  (r_total),
    .boundary   (w_boundary),
    .period_end (period_end)
  );

  assign w_accept           = cfg_valid && r_cfg_ready;
  assign w_cfg_high_clamped = (cfg_high < cfg_total) ? cfg_high : cfg_total;

`ifdef PWM_RAMP_EN
  logic [STEP_W-1:0] r_step;
  logic [WIDTH-1:0]  w_base;
  logic [WIDTH:0]    w_base_x;
  logic [WIDTH:0]    w_tgt_x;
  logic [WIDTH:0]    w_step_x;
  logic [WIDTH:0]    w_ramp;
  logic              w_unused_ramp_msb;
  logic              w_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_step <= '0;
    end else if (w_accept) begin
      r_step <= cfg_step;
    end
  end

  // One extra bit keeps base+step and the differences free of wrap-around
  always_comb begin
    w_base   = (r_high < r_tgt_total) ? r_high : r_tgt_total;
    w_base_x = {1'b0, w_base};
    w_tgt_x  = {1'b0, r_tgt_high};
    w_step_x = {{(WIDTH + 1 - STEP_W){1'b0}}, r_step};
    w_ramp   = w_tgt_x;
    if (r_step != '0) begin
      if (w_base_x <= w_tgt_x) begin
        if ((w_tgt_x - w_base_x) > w_step_x) w_ramp = w_base_x + w_step_x;
      end else begin
        if ((w_base_x - w_tgt_x) > w_step_x) w_ramp = w_base_x - w_step_x;
      end
    end
  end

  assign w_high_nxt        = w_ramp[WIDTH-1:0];
  assign w_unused_ramp_msb = w_ramp[WIDTH];
  assign w_done            = (w_high_nxt == r_tgt_high);
`else
  logic w_unused_step;

  assign w_unused_step = ^cfg_step;
  assign w_high_nxt    = r_tgt_high;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cfg_ready <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cfg_ready <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_WAIT_BOUND;
      end
      ST_WAIT_BOUND: begin
`ifdef PWM_RAMP_EN
        if (w_boundary) w_state_nxt = w_done ? ST_IDLE : ST_RAMP;
`else
        if (w_boundary) w_state_nxt = ST_IDLE;
`endif
      end
`ifdef PWM_RAMP_EN
      ST_RAMP: begin
        if (w_boundary && w_done) w_state_nxt = ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load = (r_state != ST_IDLE) && w_boundary;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_total     <= '0;
      r_high      <= '0;
      r_tgt_total <= '0;
      r_tgt_high  <= '0;
    end else begin
      if (w_accept) begin
        r_tgt_total <= cfg_total;
        r_tgt_high  <= w_cfg_high_clamped;
      end
      if (w_load) begin
        r_total <= r_tgt_total;
        r_high  <= w_high_nxt;
      end
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign busy      = r_busy;
  assign total_dur = r_total;
  assign high_dur  = r_high;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_ramp_ctrl
// Purpose  : Self-checking bench for pwm_ramp_ctrl (either PWM_RAMP_EN build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp_ctrl;

  localparam int W  = 32;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [W-1:0]  cfg_total;
  logic [W-1:0]  cfg_high;
  logic [SW-1:0] cfg_step;
  logic [W-1:0]  total_dur;
  logic [W-1:0]  high_dur;
  logic          busy;
  logic          period_end;

  always #5 clk = ~clk;

  pwm_ramp_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_total  (cfg_total),
    .cfg_high   (cfg_high),
    .cfg_step   (cfg_step),
    .total_dur  (total_dur),
    .high_dur   (high_dur),
    .busy       (busy),
    .period_end (period_end)
  );

  int errors = 0;
  int checks = 0;

  // Reference: a pending target is applied (one step at a time) at each
  // period wrap until the output high duration equals it.
  longint m_total, m_high, m_tick, m_tt, m_th;
  bit     m_pe, m_ready, m_busy, m_have, m_acc;
`ifdef PWM_RAMP_EN
  longint m_step;

  function automatic longint ramp_to(longint cur, longint tgt, longint st);
    if (st == 0) return tgt;
    if (cur < tgt) return (tgt - cur <= st) ? tgt : cur + st;
    return (cur - tgt <= st) ? tgt : cur - st;
  endfunction
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 50) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit     bnd;
    longint cur;
    m_acc = 0;
    if (!rst_n) begin
      m_total = 0; m_high = 0; m_tick = 0;
      m_pe = 0; m_ready = 0; m_busy = 0; m_have = 0;
    end else begin
      bnd    = (m_tick >= m_total);
      m_tick = bnd ? 0 : m_tick + 1;
      m_pe   = bnd;
      if (!m_have) begin
        if (cfg_valid && m_ready) begin
          m_have = 1;
          m_acc  = 1;
          m_tt   = cfg_total;
          m_th   = (cfg_high < cfg_total) ? cfg_high : cfg_total;
`ifdef PWM_RAMP_EN
          m_step = cfg_step;
`endif
        end
      end else if (bnd) begin
        m_total = m_tt;
        cur     = (m_high < m_tt) ? m_high : m_tt;
`ifdef PWM_RAMP_EN
        m_high  = ramp_to(cur, m_th, m_step);
`else
        m_high  = m_th;
`endif
        if (m_high == m_th) m_have = 0;
      end
      m_ready = !m_have;
      m_busy  = m_have;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("total_dur",  total_dur,  m_total);
    chk("high_dur",   high_dur,   m_high);
    chk("busy",       busy,       m_busy);
    chk("cfg_ready",  cfg_ready,  m_ready);
    chk("period_end", period_end, m_pe);
  endtask

  task automatic send(input longint t, input longint h, input longint s);
    bit ok;
    cfg_total = W'(t); cfg_high = W'(h); cfg_step = SW'(s);
    cfg_valid = 1'b1;
    ok = 0;
    for (int n = 0; n < 500; n++) begin
      cyc();
      if (m_acc) begin ok = 1; break; end
    end
    cfg_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  longint hq[$];

  task automatic wait_idle(input int budget, output int bounds, output int busy_cyc);
    bit ok;
    bounds = 0; busy_cyc = 1; ok = 0; hq.delete();
    for (int n = 0; n < budget; n++) begin
      cyc();
      if (period_end) begin bounds++; hq.push_back(high_dur); end
      if (!busy) begin ok = 1; break; end
      busy_cyc++;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  typedef struct {
    longint t;
    longint h;
    longint s;
    int     nb;
    longint seq[4];
  } vec_t;

  vec_t vecs[10];

  initial begin
    int nb, bc, exp_nb;
    longint exp_high;

    vecs[0] = '{99, 0,   0,  1, '{0, 0, 0, 0}};
    vecs[1] = '{99, 50,  20, 3, '{20, 40, 50, 0}};
    vecs[2] = '{29, 40,  8,  1, '{29, 0, 0, 0}};
    vecs[3] = '{29, 5,   8,  3, '{21, 13, 5, 0}};
    vecs[4] = '{9,  7,   3,  1, '{7, 0, 0, 0}};
    vecs[5] = '{9,  7,   0,  1, '{7, 0, 0, 0}};
    vecs[6] = '{0,  0,   1,  1, '{0, 0, 0, 0}};
    vecs[7] = '{4,  4,   1,  4, '{1, 2, 3, 4}};
    vecs[8] = '{6,  100, 2,  1, '{6, 0, 0, 0}};
    vecs[9] = '{6,  6,   5,  1, '{6, 0, 0, 0}};

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_total = '0; cfg_high = '0; cfg_step = '0;
    m_total = 0; m_high = 0; m_tick = 0; m_tt = 0; m_th = 0;
    m_pe = 0; m_ready = 0; m_busy = 0; m_have = 0; m_acc = 0;
`ifdef PWM_RAMP_EN
    m_step = 0;
`endif

    // reset held for three cycles
    for (int i = 0; i < 3; i++) cyc();
    chk("rst_total", total_dur, 0);
    chk("rst_high", high_dur, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle_pe", period_end, 1);
      chk("idle_ready", cfg_ready, 1);
    end

    // table-driven targets
    foreach (vecs[i]) begin
      send(vecs[i].t, vecs[i].h, vecs[i].s);
      wait_idle(1000, nb, bc);
`ifdef PWM_RAMP_EN
      exp_nb = vecs[i].nb;
`else
      exp_nb = 1;
`endif
      exp_high = vecs[i].seq[vecs[i].nb - 1];
      chk("vec_bounds", nb, exp_nb);
      chk("vec_total", total_dur, vecs[i].t);
      chk("vec_high", high_dur, exp_high);
`ifdef PWM_RAMP_EN
      for (int k = 0; k < vecs[i].nb && k < hq.size(); k++)
        chk("vec_seq", hq[k], vecs[i].seq[k]);
`else
      if (hq.size() > 0) chk("vec_seq", hq[0], exp_high);
`endif
      if (i == 5) chk("busy_len_ok", (bc >= 1 && bc <= 10) ? 1 : 0, 1);
      cyc();
      chk("vec_ready_back", cfg_ready, 1);
    end

    // requester holds valid with changing data while a ramp is running
    send(99, 60, 10);
    cfg_valid = 1'b1;
    begin
      bit ok;
      ok = 0;
      for (int n = 0; n < 2000; n++) begin
        if (n % 2 == 0) begin cfg_total = 50; cfg_high = 10; cfg_step = 5; end
        else            begin cfg_total = 20; cfg_high = 3;  cfg_step = 4; end
        cyc();
        if (m_acc) begin ok = 1; break; end
      end
      if (!ok) chk("hold_accept_timeout", 0, 1);
    end
    cfg_valid = 1'b0;
    wait_idle(2000, nb, bc);

    // reset in the middle of a ramp
    send(99, 80, 10);
    begin
      bit seen;
      seen = 0;
      for (int n = 0; n < 300; n++) begin
        cyc();
        if (period_end && busy) begin seen = 1; break; end
      end
`ifdef PWM_RAMP_EN
      chk("mid_ramp_reached", seen, 1);
`endif
    end
    for (int i = 0; i < 5; i++) cyc();
    rst_n = 1'b0;
    cyc();
    chk("midrst_total", total_dur, 0);
    chk("midrst_high", high_dur, 0);
    chk("midrst_busy", busy, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    chk("midrst_high_stays", high_dur, 0);

    // randomized traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      cfg_valid = $urandom_range(0, 1) == 1;
      cfg_total = W'($urandom_range(0, 12));
      cfg_high  = W'($urandom_range(0, 15));
      cfg_step  = SW'($urandom_range(0, 5));
      cyc();
    end
    rst_n = 1'b1; cfg_valid = 1'b0;
    for (int i = 0; i < 5; i++) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
